// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host-side transmit and receive paths:
// FSM state encoding, frame geometry and well-known command bytes.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    WAIT_START,
    TX,
    WAIT_IDLE
  } state_t;

  // start + 8 data + parity + stop; the host never drives the start bit on a fall
  localparam int FRAME_BITS = 11;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] BREAK_PREFIX = 8'hF0;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for the raw PS/2 clock and data pads plus a falling-edge
// detector on the synchronised clock. Shared by the transmit and receive paths.
module ps2_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk_in,
  input  logic ps2_dat_in,
  output logic sync_clk,
  output logic sync_dat,
  output logic fall
);

  logic clk_meta;
  logic dat_meta;
  logic prev_sync_clk;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_meta      <= 1'b0;
      sync_clk      <= 1'b0;
      prev_sync_clk <= 1'b0;
      dat_meta      <= 1'b0;
      sync_dat      <= 1'b0;
    end else begin
      clk_meta      <= ps2_clk_in;
      sync_clk      <= clk_meta;
      prev_sync_clk <= sync_clk;
      dat_meta      <= ps2_dat_in;
      sync_dat      <= dat_meta;
    end
  end

  assign fall = prev_sync_clk & ~sync_clk;

endmodule

// File: rtl/ps2_command_sender.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, clock out one command
// byte with odd parity and stop, then check the device ACK and report one status pulse.
module ps2_command_sender
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES       = 6000,
  parameter int START_TIMEOUT_CYCLES = 750000,
  parameter int BYTE_TIMEOUT_CYCLES  = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] the_command,
  input  logic       send_command,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       command_was_sent,
  output logic       error_communication_timed_out,
  output logic       error_no_ack
);

  localparam int CNT_W = $clog2(max3(INHIBIT_CYCLES, START_TIMEOUT_CYCLES,
                                     BYTE_TIMEOUT_CYCLES)) + 1;
  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] START_LAST   = CNT_W'(START_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BYTE_LAST    = CNT_W'(BYTE_TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       LAST_HOST_FALL = 4'(FRAME_BITS - 1);

  state_t                state, state_n;
  logic [CNT_W-1:0]      cnt, cnt_n, cnt_inc;
  logic [3:0]            fall_cnt, fall_cnt_n;
  logic [FRAME_BITS-2:0] shreg, shreg_n;
  logic                  clk_oe_n, dat_oe_n;
  logic                  sent_n, timeout_n, no_ack_n;
  logic                  sync_clk, sync_dat, fall;
  logic                  pulse_any;

  ps2_line_sync u_line_sync (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .sync_clk   (sync_clk),
    .sync_dat   (sync_dat),
    .fall       (fall)
  );

  // One counter serves inhibit, start timeout and byte timeout in turn; it saturates.
  assign cnt_inc   = (&cnt) ? cnt : cnt + 1'b1;
  assign pulse_any = command_was_sent | error_communication_timed_out | error_no_ack;
  assign busy      = (state != IDLE);

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt_inc;
    fall_cnt_n = fall_cnt;
    shreg_n    = shreg;
    sent_n     = 1'b0;
    timeout_n  = 1'b0;
    no_ack_n   = 1'b0;

    case (state)
      IDLE: begin
        cnt_n = '0;
        // The status-pulse cycle still counts as the end of the previous frame.
        if (send_command && !pulse_any) begin
          shreg_n = {1'b1, ~^the_command, the_command};
          state_n = INHIBIT;
        end
      end
      INHIBIT: begin
        if (cnt >= INHIBIT_LAST) begin
          state_n = RTS;
          cnt_n   = '0;
        end
      end
      RTS: begin
        state_n = WAIT_START;
        cnt_n   = '0;
      end
      WAIT_START: begin
        if (fall) begin
          state_n    = TX;
          cnt_n      = '0;
          fall_cnt_n = 4'd1;
        end else if (cnt >= START_LAST) begin
          state_n   = IDLE;
          timeout_n = 1'b1;
        end
      end
      TX: begin
        if (fall) begin
          if (fall_cnt == LAST_HOST_FALL) begin
            if (sync_dat) begin
              state_n  = IDLE;
              no_ack_n = 1'b1;
            end else begin
              state_n = WAIT_IDLE;
            end
          end else begin
            fall_cnt_n = fall_cnt + 4'd1;
            shreg_n    = {1'b1, shreg[FRAME_BITS-2:1]};
          end
        end else if (cnt >= BYTE_LAST) begin
          state_n   = IDLE;
          timeout_n = 1'b1;
        end
      end
      WAIT_IDLE: begin
        if (sync_clk && sync_dat) begin
          state_n = IDLE;
          sent_n  = 1'b1;
        end else if (cnt >= BYTE_LAST) begin
          state_n   = IDLE;
          timeout_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // Line drivers are registered from the next state so the pads never glitch.
    clk_oe_n = (state_n == INHIBIT) || (state_n == RTS);
    dat_oe_n = (state_n == RTS) || (state_n == WAIT_START) ||
               ((state_n == TX) && !shreg_n[0]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                         <= IDLE;
      cnt                           <= '0;
      fall_cnt                      <= '0;
      shreg                         <= '0;
      ps2_clk_oe                    <= 1'b0;
      ps2_dat_oe                    <= 1'b0;
      command_was_sent              <= 1'b0;
      error_communication_timed_out <= 1'b0;
      error_no_ack                  <= 1'b0;
    end else begin
      state                         <= state_n;
      cnt                           <= cnt_n;
      fall_cnt                      <= fall_cnt_n;
      shreg                         <= shreg_n;
      ps2_clk_oe                    <= clk_oe_n;
      ps2_dat_oe                    <= dat_oe_n;
      command_was_sent              <= sent_n;
      error_communication_timed_out <= timeout_n;
      error_no_ack                  <= no_ack_n;
    end
  end

endmodule

// File: tb/tb_ps2_command_sender.sv
// Bench for ps2_command_sender: a device-side BFM clocks frames out of the host,
// and a frame model (parity, bit order, timing rules) supplies every expectation.
module tb_ps2_command_sender;
  import ps2_pkg::*;

  localparam int INH = 10;
  localparam int STO = 200;
  localparam int BTO = 2000;

  localparam int M_ACK    = 0;
  localparam int M_NOACK  = 1;
  localparam int M_SILENT = 2;
  localparam int M_ABORT  = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] the_command = 8'h00;
  logic       send_command = 1'b0;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  logic       ps2_clk_in, ps2_dat_in;
  logic       ps2_clk_oe, ps2_dat_oe, busy;
  logic       command_was_sent, error_communication_timed_out, error_no_ack;

  int         total = 0;
  int         bad = 0;
  logic       got_sent, got_to, got_noack;
  logic       frame_pulsed = 1'b0;
  logic [9:0] rec;

  // Open-drain wires with pull-ups: either side may pull low.
  assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

  ps2_command_sender #(
    .INHIBIT_CYCLES       (INH),
    .START_TIMEOUT_CYCLES (STO),
    .BYTE_TIMEOUT_CYCLES  (BTO)
  ) dut (
    .clk                           (clk),
    .reset                         (reset),
    .the_command                   (the_command),
    .send_command                  (send_command),
    .ps2_clk_in                    (ps2_clk_in),
    .ps2_dat_in                    (ps2_dat_in),
    .ps2_clk_oe                    (ps2_clk_oe),
    .ps2_dat_oe                    (ps2_dat_oe),
    .busy                          (busy),
    .command_was_sent              (command_was_sent),
    .error_communication_timed_out (error_communication_timed_out),
    .error_no_ack                  (error_no_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Bits the device must see after falls 1..10: data LSB first, odd parity, stop.
  function automatic logic [9:0] model_frame(input logic [7:0] c);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(c[i]);
    return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, c};
  endfunction

  task automatic tick();
    @(negedge clk);
    if (command_was_sent)              got_sent  = 1'b1;
    if (error_communication_timed_out) got_to    = 1'b1;
    if (error_no_ack)                  got_noack = 1'b1;
  endtask

  // Idle rules and pulse discipline, checked on every cycle out of reset.
  always @(negedge clk) begin
    if (reset) begin
      frame_pulsed = 1'b0;
    end else begin
      if (!busy) check("idle_lines_released", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
      if (command_was_sent | error_communication_timed_out | error_no_ack) begin
        check("pulse_only_when_idle", busy, 0);
        check("pulse_onehot",
              $countones({command_was_sent, error_communication_timed_out, error_no_ack}), 1);
        check("one_pulse_per_frame", frame_pulsed, 0);
        frame_pulsed = 1'b1;
      end else if (busy) begin
        frame_pulsed = 1'b0;
      end
    end
  end

  task automatic run_frame(input logic [7:0] cmd, input int mode, input int lo, input int hi,
                           input bit inject);
    int n;
    int kmax;
    logic [2:0] want;
    got_sent = 1'b0; got_to = 1'b0; got_noack = 1'b0; rec = '0;
    the_command  = cmd;
    send_command = 1'b1;
    tick();
    send_command = 1'b0;
    check("accepted", busy, 1);
    n = 0;
    while (ps2_clk_oe && !ps2_dat_oe && n < 100) begin n++; tick(); end
    check("inhibit_len", n, INH);
    n = 0;
    while (ps2_clk_oe && ps2_dat_oe && n < 100) begin n++; tick(); end
    check("rts_len", n, 1);
    check("wait_start_lines", {ps2_clk_oe, ps2_dat_oe}, 2'b01);

    if (mode == M_SILENT) begin
      n = 0;
      while (!got_to && n < 1000) begin n++; tick(); end
      check("start_timeout_at", n, STO);
      check("result", {got_sent, got_to, got_noack}, 3'b010);
      return;
    end

    repeat (30) tick();
    kmax = (mode == M_ABORT) ? 5 : 11;
    for (int k = 1; k <= kmax; k++) begin
      dev_clk_low = 1'b1;
      for (int c = 0; c < lo; c++) begin
        if (inject && k == 4 && c == 5) begin the_command = 8'h00; send_command = 1'b1; end
        if (inject && k == 4 && c == 6) send_command = 1'b0;
        tick();
      end
      if (k <= 10) rec[k-1] = ps2_dat_in;
      if (mode == M_ABORT && k == 5) begin
        #3 reset = 1'b1;
        #1 check("abort_outputs_async",
                 {ps2_clk_oe, ps2_dat_oe, busy, command_was_sent,
                  error_communication_timed_out, error_no_ack}, 6'b0);
        dev_clk_low = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        repeat (20) tick();
        check("abort_no_pulse", {got_sent, got_to, got_noack}, 3'b000);
        check("abort_bits_so_far", rec[3:0], model_frame(cmd) & 10'h00F);
        return;
      end
      dev_clk_low = 1'b0;
      if (k == 10 && mode == M_ACK) dev_dat_low = 1'b1;
      if (k == 11) dev_dat_low = 1'b0;
      else repeat (hi) tick();
    end

    n = 0;
    while (!(got_sent | got_to | got_noack) && n < 3000) begin n++; tick(); end
    want = (mode == M_ACK) ? 3'b100 : 3'b001;
    check("result", {got_sent, got_to, got_noack}, want);
    check("frame_bits", rec, model_frame(cmd));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] cmd;
    int lo, hi;
    #1 reset = 1'b1;
    #1 check("reset_outputs",
             {ps2_clk_oe, ps2_dat_oe, busy, command_was_sent,
              error_communication_timed_out, error_no_ack}, 6'b0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) tick();
    check("idle_after_reset", {busy, ps2_clk_oe, ps2_dat_oe}, 3'b000);

    run_frame(CMD_SET_LEDS, M_ACK, 20, 20, 1'b0);
    check("ed_wire_literal", rec, 10'h3ED);
    repeat (5) tick();

    // Second request lands in the pulse cycle (ignored), then is held one more cycle.
    run_frame(CMD_ENABLE, M_ACK, 20, 20, 1'b0);
    check("f4_wire_literal", rec, 10'h2F4);
    the_command  = CMD_RESET;
    send_command = 1'b1;
    tick();
    check("ignored_in_pulse_cycle", busy, 0);
    run_frame(CMD_RESET, M_ACK, 20, 20, 1'b0);
    check("ff_wire_literal", rec, 10'h3FF);
    repeat (5) tick();

    run_frame(CMD_ENABLE, M_SILENT, 20, 20, 1'b0);
    repeat (5) tick();

    run_frame(CMD_RESET, M_NOACK, 20, 20, 1'b0);
    repeat (30) tick();

    run_frame(CMD_SET_LEDS, M_ACK, 20, 20, 1'b1);
    check("inject_ignored_literal", rec, 10'h3ED);
    repeat (5) tick();

    run_frame(CMD_SET_LEDS, M_ABORT, 20, 20, 1'b0);
    run_frame(CMD_SET_LEDS, M_ACK, 20, 20, 1'b0);
    repeat (5) tick();

    for (int i = 0; i < 5; i++) begin
      cmd = (i == 0) ? BREAK_PREFIX : 8'($urandom);
      lo  = int'($urandom_range(25, 12));
      hi  = int'($urandom_range(25, 12));
      run_frame(cmd, M_ACK, lo, hi, 1'b0);
      repeat (int'($urandom_range(8, 2))) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
